// File: rtl/mc_scoreboard.sv
// Issue-side scoreboard for the multi-cycle MUL/DIV units: tracks in-flight destinations,
// raises the ID stall, sequences each FU with a latency counter and arbitrates the shared WB port.
module mc_scoreboard #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_ID,
  input  logic        mc_op_ID,
  input  logic        fu_sel_ID,
  input  logic        rs1use_ID,
  input  logic        rs2use_ID,
  input  logic        reg_write_ID,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic [4:0]  rd_ID,
  input  logic        ext_stall_ID,
  input  logic        flush_ID,
  input  logic        wb_ready,
  output logic        sb_stall_ID,
  output logic        issue_fire,
  output logic [1:0]  fu_start,
  output logic [1:0]  fu_busy,
  output logic        wb_valid,
  output logic        wb_fu,
  output logic [4:0]  wb_rd,
  output logic [31:0] pending
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fu_state_t;

  fu_state_t        st    [2];
  logic [CNT_W-1:0] cnt   [2];
  logic [4:0]       fu_rd [2];

  logic [1:0]  fu_done;
  logic        raw_hz, waw_hz, struct_hz;
  logic        wb_fire;
  logic [31:0] set_mask, clr_mask;

  function automatic logic [CNT_W-1:0] lat_load(input logic sel);
    lat_load = sel ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
  endfunction

  always_comb begin
    for (int f = 0; f < 2; f++) begin
      fu_busy[f] = (st[f] != IDLE);
      fu_done[f] = (st[f] == DONE);
    end
  end

  // Stall depends only on ID contents and scoreboard state, never on ext_stall_ID/flush_ID.
  assign raw_hz      = (rs1use_ID && rs1_ID != 5'd0 && pending[rs1_ID]) ||
                       (rs2use_ID && rs2_ID != 5'd0 && pending[rs2_ID]);
  assign waw_hz      = reg_write_ID && rd_ID != 5'd0 && pending[rd_ID];
  assign struct_hz   = mc_op_ID && fu_busy[fu_sel_ID];
  assign sb_stall_ID = valid_ID && (raw_hz || waw_hz || struct_hz);

  assign issue_fire  = !rst && valid_ID && mc_op_ID && !sb_stall_ID && !ext_stall_ID && !flush_ID;
  assign fu_start    = issue_fire ? (fu_sel_ID ? 2'b10 : 2'b01) : 2'b00;

  // Fixed priority write-back: DIV wins over MUL.
  assign wb_valid = |fu_done;
  assign wb_fu    = fu_done[1];
  assign wb_rd    = fu_done[1] ? fu_rd[1] : (fu_done[0] ? fu_rd[0] : 5'd0);
  assign wb_fire  = wb_valid && wb_ready;

  assign clr_mask = wb_fire ? (32'd1 << wb_rd) : 32'd0;
  assign set_mask = (issue_fire && reg_write_ID && rd_ID != 5'd0) ? (32'd1 << rd_ID) : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < 2; f++) begin
        st[f]  <= IDLE;
        cnt[f] <= '0;
      end
    end else begin
      for (int f = 0; f < 2; f++) begin
        case (st[f])
          IDLE: begin
            if (issue_fire && fu_sel_ID == 1'(f)) begin
              st[f]  <= BUSY;
              cnt[f] <= lat_load(1'(f));
            end
          end
          BUSY: begin
            cnt[f] <= cnt[f] - CNT_W'(1);
            if (cnt[f] == CNT_W'(1)) st[f] <= DONE;
          end
          DONE: begin
            if (wb_ready && wb_fu == 1'(f)) st[f] <= IDLE;
          end
          default: st[f] <= IDLE;
        endcase
      end
    end
  end

  // Destination latch is data only; it is never observed unless its FU reaches DONE.
  always_ff @(posedge clk) begin
    if (issue_fire) fu_rd[fu_sel_ID] <= rd_ID;
  end

  // Set is applied after clear so a same-cycle set of the same bit wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
  end

endmodule
